// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-bit multiply/divide unit owning the HI/LO registers.
// One bit per cycle (shift-add / restoring divide), then one fix-up cycle for signs.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       muldivOP,
    input  logic             muldivWE,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic is_div, sq, sr, div0;
    logic [WIDTH-1:0] acc, low, opd, rs_raw, rs_abs, rt_abs;
    logic [WIDTH:0] add_sum, rem_sh, rem_sub;
    logic [2*WIDTH-1:0] prod;
    logic start, sgn;
    assign start   = state == IDLE && muldivWE && !muldivOP[2];
    assign sgn     = !muldivOP[0];
    assign rs_abs  = sgn && rs_val[WIDTH-1] ? -rs_val : rs_val;
    assign rt_abs  = sgn && rt_val[WIDTH-1] ? -rt_val : rt_val;
    assign add_sum = {1'b0, acc} + (low[0] ? {1'b0, opd} : '0);
    assign rem_sh  = {acc, low[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, opd};
    assign prod    = sq ? -{acc, low} : {acc, low};
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (start ? CALC : IDLE) :
                    state == CALC ? (cnt == CNT_W'(WIDTH - 1) ? FIX : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            is_div <= 1'b0;
            sq <= 1'b0;
            sr <= 1'b0;
            div0 <= 1'b0;
            acc <= '0;
            low <= '0;
            opd <= '0;
            rs_raw <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            done <= state == FIX;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        low <= rs_abs;
                        opd <= rt_abs;
                        is_div <= muldivOP[1];
                        sq <= sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        sr <= sgn & rs_val[WIDTH-1];
                        div0 <= rt_val == '0;
                        rs_raw <= rs_val;
                        cnt <= '0;
                        busy <= 1'b1;
                    end else if (muldivWE && muldivOP == 3'b100) hi <= rs_val;
                    else if (muldivWE && muldivOP == 3'b101) lo <= rs_val;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    // restoring step keeps the old remainder when the trial subtract borrows
                    if (is_div) begin
                        acc <= rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], ~rem_sub[WIDTH]};
                    end else {acc, low} <= {add_sum, low[WIDTH-1:1]};
                end
                default: begin
                    busy <= 1'b0;
                    if (is_div) begin
                        lo <= div0 ? '1 : (sq ? -low : low);
                        hi <= div0 ? rs_raw : (sr ? -acc : acc);
                    end else {hi, lo} <= prod;
                end
            endcase
        end
    end
endmodule
